uart_receive: RTL
=================

// Module: uart_receive
// PURPOSE
//  UART receiver for the 8N1 link: 8 data bits, LSB first, no parity, 1 stop bit, idle-high line.
//  Default rate is 2,700,000 baud at 27 MHz (WAIT_CYCLES clocks per bit).
//  Synchronises the rx pin, validates the start bit, samples mid-bit and holds the byte for the host.
//  Holding is a 1-deep buffer with a valid/ack handshake; framing and overrun errors are flagged.
//  Sits between the host-side uart_rx pin and the command decoder, as the peer of the team's uart_send.
// PARAMETERS
//  WAIT_CYCLES  10  clocks per bit; must be >= 4; counter width = $clog2(WAIT_CYCLES+1)
//  HALF_CYCLES  WAIT_CYCLES/2  clocks from detected falling edge to start-bit mid-sample
// PORTS
//  clk          in   1  system clock (27 MHz)
//  rst_n        in   1  asynchronous, active-low reset
//  uart_rx      in   1  serial input, asynchronous to clk, idle high
//  data         out  8  received byte; stable while byteAvailable=1
//  byteAvailable out 1  high from byte capture until the cycle readByte is sampled high
//  readByte     in   1  host ack; consumes the buffered byte; ignored when byteAvailable=0
//  frameError   out  1  one-cycle pulse: stop bit sampled low
//  overrun      out  1  sticky; set when a byte completes while byteAvailable=1 and readByte=0; cleared by readByte
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, data=0, byteAvailable=0, frameError=0, overrun=0, counter=0.
//    Both synchroniser flops reset to 1; a frame in flight is discarded.
//  rx_s is the output of the 2-FF synchroniser, i.e. 2 cycles of latency. All decisions use rx_s only.
//  Single counter: resets to 1 on each state entry, increments every clock; "tick" means counter==target.
//  IDLE: wait for rx_s falling edge (prev=1, now=0) -> START, counter=1.
//  START: at counter==HALF_CYCLES sample rx_s.
//    rx_s=1: glitch -> IDLE, no flags.
//    rx_s=0: -> BIT0, counter=1.
//  BIT0..BIT7: at counter==WAIT_CYCLES shift rx_s into shreg[n] (LSB first), counter=1, advance to the next bit.
//    BIT7 advances to STOP.
//  STOP: at counter==WAIT_CYCLES sample rx_s.
//    rx_s=1: capture shreg, -> IDLE immediately, so the next start edge can arrive half a bit later.
//    rx_s=0: frameError pulse for 1 cycle, byte dropped, -> BREAK.
//  BREAK: wait for rx_s=1, then -> IDLE. A held-low line yields exactly one frameError and no bytes.
//  Capture, in the cycle after the stop sample:
//    byteAvailable=0, or readByte=1 in the same cycle: data<=shreg, byteAvailable<=1, overrun unchanged.
//    Otherwise: the old byte is kept, the new byte is dropped, overrun<=1.
//  readByte=1 with no capture in the same cycle: byteAvailable<=0, overrun<=0.
//  Latency: stop-bit sample to byteAvailable high is 1 clock; pin edge to stop sample is 2 + HALF_CYCLES + 9*WAIT_CYCLES clocks.
//  Tolerance: sampling at the bit centre gives about ±4% total clock mismatch at 8N1.
//  States are one-hot-free 4-bit codes: IDLE, START, BIT0..BIT7 (0000..0111), STOP, BREAK.
// STRUCTURE
//  uart_pkg (shared): RX state localparams, UART_DEFAULT_WAIT_CYCLES=10, DATA_BITS=8.
//  Sub-module uart_rx_sync: 2-FF synchroniser with async active-low reset to 1 (reused by future inputs).
//  Top: FSM + bit counter, shift register, holding register, flag logic; about 150 lines.
// TESTING (WAIT_CYCLES=10, clk 27 MHz, bit period 10 clocks)
//  1 Frame 0xA5 -> byteAvailable rises exactly 2+5+90+1 clocks after the rx fall, data=0xA5, no flags.
//    Pulse readByte -> byteAvailable=0 next clock.
//  2 rx low for 3 clocks then high -> no byteAvailable, no frameError, FSM back in IDLE.
//  3 Frame with stop bit 0, line held low 40 clocks -> exactly one frameError pulse, no byte.
//    Next, frame 0x3C -> data=0x3C.
//  4 Back-to-back 0x00 then 0xFF, readByte asserted in the capture cycle of 0xFF.
//    Result: both bytes delivered in order, overrun=0.
//  5 Frames 0x11 then 0x22 with no readByte -> data stays 0x11, overrun=1.
//    readByte -> overrun=0, byteAvailable=0.
//  6 rst_n pulsed low mid-BIT4 of a frame -> outputs 0 immediately; the partial frame is never delivered.
//    Then a uart_send loopback of 256 random bytes -> all received, no flags.

Source files
------------

// File: rtl/uart_receive_pkg.sv
// rtl/uart_receive_pkg.sv - shared constants and receiver state codes for the 8N1 UART receiver
package uart_receive_pkg;

  localparam int UART_DEFAULT_WAIT_CYCLES = 10;
  localparam int DATA_BITS                = 8;

  // Data-bit states are numbered 0..7 so the state code doubles as the bit index.
  typedef enum logic [3:0] {
    ST_BIT0  = 4'd0,
    ST_BIT1  = 4'd1,
    ST_BIT2  = 4'd2,
    ST_BIT3  = 4'd3,
    ST_BIT4  = 4'd4,
    ST_BIT5  = 4'd5,
    ST_BIT6  = 4'd6,
    ST_BIT7  = 4'd7,
    ST_STOP  = 4'd8,
    ST_BREAK = 4'd9,
    ST_IDLE  = 4'd10,
    ST_START = 4'd11
  } rx_state_e;

endpackage

// File: rtl/uart_receive_if.sv
// rtl/uart_receive_if.sv - host-side byte handshake between the receiver and the command decoder
interface uart_receive_if;
  import uart_receive_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 byteAvailable;
  logic                 readByte;
  logic                 frameError;
  logic                 overrun;

  modport master (output data, byteAvailable, frameError, overrun, input readByte);
  modport slave  (input data, byteAvailable, frameError, overrun, output readByte);

endinterface

// File: rtl/uart_receive_sync.sv
// rtl/uart_receive_sync.sv - two-flop synchroniser that resets to the idle-high line level
module uart_receive_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1 UART receiver with mid-bit sampling and a one-deep holding buffer
module uart_receive
  import uart_receive_pkg::*;
#(
  parameter int WAIT_CYCLES = UART_DEFAULT_WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           uart_rx,
  uart_receive_if.master host
);

  localparam int HALF_CYCLES = WAIT_CYCLES / 2;
  localparam int CW          = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_TGT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] HALF_TGT = CW'(HALF_CYCLES);

  logic                 rx_s;
  logic                 rx_prev;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick_wait;
  logic                 tick_half;
  logic                 capture;

  uart_receive_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rx_s)
  );

  assign tick_wait = (cnt == WAIT_TGT);
  assign tick_half = (cnt == HALF_TGT);
  assign capture   = (state == ST_STOP) && tick_wait && rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      shreg            <= '0;
      rx_prev          <= 1'b1;
      host.frameError  <= 1'b0;
    end else begin
      rx_prev         <= rx_s;
      cnt             <= cnt + 1'b1;
      host.frameError <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= ST_START;
            cnt   <= CW'(1);
          end
        end
        ST_START: begin
          // A start bit that has gone high again by mid-bit is treated as line noise.
          if (tick_half) begin
            state <= rx_s ? ST_IDLE : ST_BIT0;
            cnt   <= CW'(1);
          end
        end
        ST_BIT0, ST_BIT1, ST_BIT2, ST_BIT3,
        ST_BIT4, ST_BIT5, ST_BIT6, ST_BIT7: begin
          if (tick_wait) begin
            shreg[state[2:0]] <= rx_s;
            state             <= rx_state_e'(state + 4'd1);
            cnt               <= CW'(1);
          end
        end
        ST_STOP: begin
          if (tick_wait) begin
            cnt <= CW'(1);
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              host.frameError <= 1'b1;
              state           <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            cnt   <= CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= CW'(1);
        end
      endcase
    end
  end

  // A same-cycle ack frees the buffer for the incoming byte without touching overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host.data          <= '0;
      host.byteAvailable <= 1'b0;
      host.overrun       <= 1'b0;
    end else if (capture) begin
      if (!host.byteAvailable || host.readByte) begin
        host.data          <= shreg;
        host.byteAvailable <= 1'b1;
      end else begin
        host.overrun <= 1'b1;
      end
    end else if (host.readByte) begin
      host.byteAvailable <= 1'b0;
      host.overrun       <= 1'b0;
    end
  end

endmodule
